// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the signed ALU: buffers commands,
// issues one at a time, captures the result and guards with a watchdog.
// Ports:
//   CLK, RST (async active-low)
//   CMD_VALID/CMD_READY/CMD_FUN/CMD_A/CMD_B      : command input
//   ALU_A/ALU_B/ALU_FUN/ALU_START               : ALU issue
//   ALU_RES/ALU_RES_VALID                       : ALU response
//   RES_OUT/RES_FUN/RES_VALID/RES_READY         : result output
//   ERR_TIMEOUT (sticky), BUSY
module alu_cmd_sequencer #(
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [3:0]           CMD_FUN,
  input  logic [WIDTH-1:0]     CMD_A,
  input  logic [WIDTH-1:0]     CMD_B,
  output logic [WIDTH-1:0]     ALU_A,
  output logic [WIDTH-1:0]     ALU_B,
  output logic [3:0]           ALU_FUN,
  output logic                 ALU_START,
  input  logic [RES_WIDTH-1:0] ALU_RES,
  input  logic                 ALU_RES_VALID,
  output logic [RES_WIDTH-1:0] RES_OUT,
  output logic [3:0]           RES_FUN,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic                 ERR_TIMEOUT,
  output logic                 BUSY
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  logic [WIDTH-1:0] a_mem [DEPTH];
  logic [WIDTH-1:0] b_mem [DEPTH];
  logic [3:0]       f_mem [DEPTH];

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rdy_en_q, rdy_en_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [3:0]           alu_fun_q, alu_fun_d;
  logic                 start_q, start_d;
  logic [TW-1:0]        wd_q, wd_d;
  logic [RES_WIDTH-1:0] res_out_q, res_out_d;
  logic [3:0]           res_fun_q, res_fun_d;
  logic                 res_valid_q, res_valid_d;
  logic                 err_q, err_d;

  logic          push;
  logic          pop;
  logic [TW-1:0] wd_inc;

  // Ready is held low until the first edge after reset release.
  assign CMD_READY = rdy_en_q && (cnt_q != CW'(DEPTH));
  assign push      = CMD_VALID && CMD_READY;
  assign wd_inc    = wd_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    start_d     = 1'b0;
    wd_d        = wd_q;
    res_out_d   = res_out_q;
    res_fun_d   = res_fun_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop       = 1'b1;
          alu_a_d   = a_mem[rd_ptr_q];
          alu_b_d   = b_mem[rd_ptr_q];
          alu_fun_d = f_mem[rd_ptr_q];
          start_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_inc;
        if (ALU_RES_VALID) begin
          res_out_d   = ALU_RES;
          res_fun_d   = alu_fun_q;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (wd_inc == TW'(TIMEOUT)) begin
          err_d       = 1'b1;
          res_out_d   = '0;
          res_fun_d   = alu_fun_q;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_en_d = 1'b1;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Storage needs no reset: count and pointers gate every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      a_mem[wr_ptr_q] <= CMD_A;
      b_mem[wr_ptr_q] <= CMD_B;
      f_mem[wr_ptr_q] <= CMD_FUN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      start_q     <= 1'b0;
      wd_q        <= '0;
      res_out_q   <= '0;
      res_fun_q   <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= rdy_en_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      start_q     <= start_d;
      wd_q        <= wd_d;
      res_out_q   <= res_out_d;
      res_fun_q   <= res_fun_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign ALU_A       = alu_a_q;
  assign ALU_B       = alu_b_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_START   = start_q;
  assign RES_OUT     = res_out_q;
  assign RES_FUN     = res_fun_q;
  assign RES_VALID   = res_valid_q;
  assign ERR_TIMEOUT = err_q;
  assign BUSY        = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: scoreboard of expected results,
// a behavioural ALU stand-in, and one task per scenario.
module tb_alu_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [3:0]  CMD_FUN = '0;
  logic [15:0] CMD_A = '0;
  logic [15:0] CMD_B = '0;
  logic [15:0] ALU_A;
  logic [15:0] ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_START;
  logic [31:0] ALU_RES;
  logic        ALU_RES_VALID;
  logic [31:0] RES_OUT;
  logic [3:0]  RES_FUN;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic        ERR_TIMEOUT;
  logic        BUSY;

  alu_cmd_sequencer #(
    .WIDTH(16), .RES_WIDTH(32), .DEPTH(4), .TIMEOUT(15)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_FUN(CMD_FUN), .CMD_A(CMD_A), .CMD_B(CMD_B),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_START(ALU_START),
    .ALU_RES(ALU_RES), .ALU_RES_VALID(ALU_RES_VALID),
    .RES_OUT(RES_OUT), .RES_FUN(RES_FUN),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .ERR_TIMEOUT(ERR_TIMEOUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  fun;
    logic [31:0] res;
    bit          tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  bit   alu_mute = 1'b0;
  bit   stray_v = 1'b0;
  bit   pend = 1'b0;
  logic [31:0] pend_res = '0;
  logic [31:0] model_r = '0;
  logic        model_v = 1'b0;

  function automatic logic [31:0] alu_model(
    input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    if (f[3:2] == 2'b00)
      return {{16{a[15]}}, a} + {{16{b[15]}}, b};
    return {a, b} ^ {28'h0, f};
  endfunction

  function automatic void sb_push(
    input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.fun = f;
    e.tmo = alu_mute;
    e.res = alu_mute ? 32'h0 : alu_model(f, a, b);
    sb.push_back(e);
  endfunction

  assign ALU_RES_VALID = model_v | stray_v;
  assign ALU_RES       = stray_v ? 32'hDEAD_BEEF : model_r;

  // ALU stand-in: answers one cycle after the start strobe.
  always begin
    @(posedge CLK);
    #1;
    model_v = 1'b0;
    if (pend) begin
      model_v = 1'b1;
      model_r = pend_res;
      pend    = 1'b0;
    end
    if (ALU_START && !alu_mute && RST) begin
      pend     = 1'b1;
      pend_res = alu_model(ALU_FUN, ALU_A, ALU_B);
    end
  end

  // Scoreboard: a result is consumed on the edge after this sample.
  always @(negedge CLK) begin
    if (RST) begin
      if (ALU_START) start_cnt++;
      if (RES_VALID && RES_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected out=%h fun=%h required none",
                   RES_OUT, RES_FUN);
        end else begin
          mon_e = sb.pop_front();
          if (RES_OUT !== mon_e.res ||
              (!mon_e.tmo && RES_FUN !== mon_e.fun)) begin
            errors++;
            $display("FAIL sb_result out=%h fun=%h required out=%h fun=%h",
                     RES_OUT, RES_FUN, mon_e.res, mon_e.fun);
          end
        end
      end
    end
  end

  task automatic push_cmd(
    input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    bit ok = 1'b0;
    CMD_VALID = 1'b1;
    CMD_FUN   = f;
    CMD_A     = a;
    CMD_B     = b;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge CLK);
      ok = CMD_READY;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept ready=%b required 1", CMD_READY);
    end else begin
      sb_push(f, a, b);
    end
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!RES_VALID && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checks++;
    if (RES_VALID !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid res_valid=%b required 1", RES_VALID);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({ALU_A, ALU_B, ALU_FUN, RES_OUT, RES_FUN, ALU_START, RES_VALID,
         ERR_TIMEOUT, BUSY, CMD_READY} !== '0) begin
      errors++;
      $display("FAIL reset_outputs a=%h b=%h f=%h o=%h rf=%h st=%b v=%b e=%b bsy=%b rdy=%b required all 0",
               ALU_A, ALU_B, ALU_FUN, RES_OUT, RES_FUN, ALU_START,
               RES_VALID, ERR_TIMEOUT, BUSY, CMD_READY);
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if (CMD_READY !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge ready=%b required 0", CMD_READY);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge ready=%b busy=%b required 1 0",
               CMD_READY, BUSY);
    end
  endtask

  task automatic test_single();
    int s0 = start_cnt;
    RES_READY = 1'b1;
    CMD_VALID = 1'b1;
    CMD_FUN   = 4'b0000;
    CMD_A     = 16'd5;
    CMD_B     = 16'hFFFD;
    sb_push(4'b0000, 16'd5, 16'hFFFD);
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (ALU_START !== 1'b1 || ALU_A !== 16'd5 || ALU_B !== 16'hFFFD ||
        ALU_FUN !== 4'h0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_issue st=%b a=%h b=%h f=%h bsy=%b required 1 0005 fffd 0 1",
               ALU_START, ALU_A, ALU_B, ALU_FUN, BUSY);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (ALU_START !== 1'b0 || RES_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_wait st=%b v=%b required 0 0",
               ALU_START, RES_VALID);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 32'd2 || RES_FUN !== 4'h0) begin
      errors++;
      $display("FAIL single_result v=%b out=%h fun=%h required 1 00000002 0",
               RES_VALID, RES_OUT, RES_FUN);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL single_starts count=%0d required 1", start_cnt - s0);
    end
    wait_drain();
  endtask

  task automatic test_fill();
    logic [3:0] funs [6];
    int k = 0;
    bit dropped = 1'b0;
    funs = '{4'h1, 4'h5, 4'h9, 4'hD, 4'h2, 4'h6};
    RES_READY = 1'b0;
    CMD_VALID = 1'b1;
    CMD_FUN   = funs[0];
    CMD_A     = 16'(1);
    CMD_B     = 16'(5);
    for (int c = 0; c < 20 && !dropped; c++) begin
      @(negedge CLK);
      if (CMD_READY) begin
        sb_push(CMD_FUN, CMD_A, CMD_B);
        k++;
      end else begin
        dropped = 1'b1;
      end
      @(posedge CLK);
      #1;
      if (k < 6) begin
        CMD_FUN = funs[k];
        CMD_A   = 16'(1000 * k + 1);
        CMD_B   = 16'(5 - 3 * k);
      end
    end
    checks++;
    if (!dropped || k != 5) begin
      errors++;
      $display("FAIL fill_accepted count=%0d dropped=%b required 5 1",
               k, dropped);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (CMD_READY !== 1'b0) begin
        errors++;
        $display("FAIL fill_full ready=%b required 0", CMD_READY);
      end
    end
    @(posedge CLK);
    #1;
    RES_READY = 1'b1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      @(negedge CLK);
      if (CMD_READY) begin
        sb_push(CMD_FUN, CMD_A, CMD_B);
        k++;
      end
      @(posedge CLK);
      #1;
    end
    CMD_VALID = 1'b0;
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL fill_sixth count=%0d required 6", k);
    end
    wait_drain();
  endtask

  task automatic test_hold();
    logic [31:0] o;
    logic [3:0]  f;
    int s0;
    RES_READY = 1'b0;
    push_cmd(4'h7, 16'h1234, 16'h00FF);
    wait_valid();
    o  = RES_OUT;
    f  = RES_FUN;
    s0 = start_cnt;
    push_cmd(4'hB, 16'h8001, 16'h7FFF);
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (RES_VALID !== 1'b1 || RES_OUT !== o || RES_FUN !== f ||
          start_cnt != s0) begin
        errors++;
        $display("FAIL hold_stable v=%b out=%h fun=%h starts=%0d required 1 %h %h %0d",
                 RES_VALID, RES_OUT, RES_FUN, start_cnt, o, f, s0);
      end
    end
    RES_READY = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (ALU_START !== 1'b0 || RES_VALID !== 1'b0) begin
      errors++;
      $display("FAIL hold_release st=%b v=%b required 0 0",
               ALU_START, RES_VALID);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (ALU_START !== 1'b1 || ALU_FUN !== 4'hB) begin
      errors++;
      $display("FAIL hold_next_issue st=%b f=%h required 1 b",
               ALU_START, ALU_FUN);
    end
    wait_drain();
  endtask

  task automatic test_timeout();
    int n = 0;
    alu_mute  = 1'b1;
    RES_READY = 1'b1;
    push_cmd(4'hC, 16'h8000, 16'h0001);
    while (!ALU_START && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checks++;
    if (ALU_START !== 1'b1) begin
      errors++;
      $display("FAIL tmo_issue st=%b required 1", ALU_START);
    end
    repeat (15) @(posedge CLK);
    #1;
    checks++;
    if (ERR_TIMEOUT !== 1'b0 || RES_VALID !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early err=%b v=%b required 0 0",
               ERR_TIMEOUT, RES_VALID);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (ERR_TIMEOUT !== 1'b1 || RES_VALID !== 1'b1 ||
        RES_OUT !== 32'h0) begin
      errors++;
      $display("FAIL tmo_fire err=%b v=%b out=%h required 1 1 00000000",
               ERR_TIMEOUT, RES_VALID, RES_OUT);
    end
    wait_drain();
    alu_mute = 1'b0;
    push_cmd(4'h3, 16'd100, 16'hFF38);
    wait_drain();
    checks++;
    if (ERR_TIMEOUT !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky err=%b required 1", ERR_TIMEOUT);
    end
  endtask

  task automatic test_stray();
    logic [31:0] o;
    logic [3:0]  f;
    int s0;
    RES_READY = 1'b1;
    o  = RES_OUT;
    s0 = start_cnt;
    stray_v = 1'b1;
    @(posedge CLK);
    #1;
    stray_v = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (RES_VALID !== 1'b0 || RES_OUT !== o || BUSY !== 1'b0 ||
        start_cnt != s0) begin
      errors++;
      $display("FAIL stray_idle v=%b out=%h bsy=%b starts=%0d required 0 %h 0 %0d",
               RES_VALID, RES_OUT, BUSY, start_cnt, o, s0);
    end
    RES_READY = 1'b0;
    push_cmd(4'h9, 16'hA5A5, 16'h5A5A);
    wait_valid();
    o = RES_OUT;
    f = RES_FUN;
    stray_v = 1'b1;
    @(posedge CLK);
    #1;
    stray_v = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (RES_VALID !== 1'b1 || RES_OUT !== o || RES_FUN !== f) begin
      errors++;
      $display("FAIL stray_hold v=%b out=%h fun=%h required 1 %h %h",
               RES_VALID, RES_OUT, RES_FUN, o, f);
    end
    RES_READY = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int s0;
    alu_mute  = 1'b1;
    RES_READY = 1'b0;
    push_cmd(4'h1, 16'h0011, 16'h0022);
    push_cmd(4'h5, 16'h0033, 16'h0044);
    push_cmd(4'h9, 16'h0055, 16'h0066);
    push_cmd(4'hD, 16'h0077, 16'h0088);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    checks++;
    if ({ALU_A, ALU_B, ALU_FUN, RES_OUT, RES_FUN, ALU_START, RES_VALID,
         ERR_TIMEOUT, BUSY, CMD_READY} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs a=%h b=%h f=%h o=%h rf=%h st=%b v=%b e=%b bsy=%b rdy=%b required all 0",
               ALU_A, ALU_B, ALU_FUN, RES_OUT, RES_FUN, ALU_START,
               RES_VALID, ERR_TIMEOUT, BUSY, CMD_READY);
    end
    sb.delete();
    alu_mute = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    s0  = start_cnt;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (ALU_START !== 1'b0 || BUSY !== 1'b0 || CMD_READY !== 1'b1) begin
        errors++;
        $display("FAIL midreset_idle st=%b bsy=%b rdy=%b required 0 0 1",
                 ALU_START, BUSY, CMD_READY);
      end
    end
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL midreset_starts count=%0d required %0d", start_cnt, s0);
    end
    RES_READY = 1'b1;
    push_cmd(4'h0, 16'h7FFF, 16'h0001);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_hold();
    test_timeout();
    test_stray();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
